// File: rtl/ivector_heard_serializer.sv
// Buffers one IVector heard(meth, v) indication and streams it out as a
// 13-word message: a header word, then meth and v, least significant word first.
module ivector_heard_serializer #(
   parameter logic [15:0] METHOD_ID = 16'd0
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         heard__ENA,
   input  logic [191:0] heard_meth,
   input  logic [191:0] heard_v,
   output logic         heard__RDY,
   output logic         msg__ENA,
   output logic [31:0]  msg_data,
   output logic         msg_last,
   input  logic         msg__RDY,
   output logic [15:0]  msg_count
);

   localparam logic [3:0]  LAST_IDX  = 4'd12;
   localparam logic [15:0] NUM_WORDS = 16'd13;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     idx_q, idx_d;
   logic [15:0]    count_q, count_d;
   logic [383:0]   buf_q, buf_d;
   logic [31:0]    word;
   logic           busy;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         count_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples the pre-edge values of the others.
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
      end
   end

   // NOTE: the payload buffer is deliberately left out of reset; it is always
   // written before it is read, and a reset-free wide register is cheaper.
   always_ff @(posedge CLK) begin
      buf_q <= buf_d;
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      buf_d   = buf_q;
      case (state_q)
         IDLE: begin
            // heard__ENA is only honoured here, so a violating call during SEND is dropped.
            if (heard__ENA) begin
               buf_d   = {heard_v, heard_meth};
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (msg__RDY) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  count_d = count_q + 16'd1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // buf holds {v, meth}, so payload word k (1..12) is simply slice k-1.
   always_comb begin
      word = '0;
      if (idx_q == 4'd0) begin
         word = {METHOD_ID, NUM_WORDS};
      end else if (idx_q <= LAST_IDX) begin
         word = buf_q[{idx_q - 4'd1, 5'd0} +: 32];
      end
   end

   // Outputs are held quiet while nRST is low, even before the reset edge lands.
   assign busy       = nRST & (state_q == SEND);
   assign heard__RDY = nRST & (state_q == IDLE);
   assign msg__ENA   = busy & msg__RDY;
   assign msg_data   = busy ? word : 32'd0;
   assign msg_last   = busy & (idx_q == LAST_IDX);
   assign msg_count  = nRST ? count_q : 16'd0;

endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Scoreboard bench for ivector_heard_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares every transferred word.
module tb_ivector_heard_serializer;

   localparam logic [15:0] MID = 16'h0005;

   logic         CLK;
   logic         nRST;
   logic         heard__ENA;
   logic [191:0] heard_meth;
   logic [191:0] heard_v;
   logic         heard__RDY;
   logic         msg__ENA;
   logic [31:0]  msg_data;
   logic         msg_last;
   logic         msg__RDY;
   logic [15:0]  msg_count;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   word_t        exp_q[$];
   int           n_tests = 0;
   int           n_fail = 0;
   int           words_seen = 0;
   int           cyc = 0;
   logic         bp_mode = 1'b0;
   logic [15:0]  exp_count = '0;
   logic [191:0] meth_a, v_a, meth_b, v_b;

   ivector_heard_serializer #(.METHOD_ID(MID)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .heard__ENA (heard__ENA),
      .heard_meth (heard_meth),
      .heard_v    (heard_v),
      .heard__RDY (heard__RDY),
      .msg__ENA   (msg__ENA),
      .msg_data   (msg_data),
      .msg_last   (msg_last),
      .msg__RDY   (msg__RDY),
      .msg_count  (msg_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic push_msg(input logic [191:0] meth, input logic [191:0] v);
      logic [383:0] all;
      word_t        w;
      all    = {v, meth};
      w.data = {MID, 16'd13};
      w.last = 1'b0;
      exp_q.push_back(w);
      for (int k = 1; k <= 12; k++) begin
         w.data = all[32*(k-1) +: 32];
         w.last = (k == 12);
         exp_q.push_back(w);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [191:0] meth, input logic [191:0] v, output int acc_cyc);
      int budget;
      budget  = 0;
      acc_cyc = 0;
      while (!heard__RDY && budget < 100) begin
         tick();
         budget++;
      end
      if (!heard__RDY) begin
         check("send_rdy_timeout", 32'(heard__RDY), 32'd1);
         return;
      end
      push_msg(meth, v);
      heard_meth = meth;
      heard_v    = v;
      heard__ENA = 1'b1;
      tick();
      acc_cyc    = cyc;
      heard__ENA = 1'b0;
      exp_count++;
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (!heard__RDY && budget < 200) begin
         tick();
         budget++;
      end
      check("idle_timeout", 32'(heard__RDY), 32'd1);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      exp_q.delete();
      exp_count = '0;
      tick();
      tick();
      nRST = 1'b1;
   endtask

   // Monitor: scoreboard pop on each transfer, stall stability, idle data.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      logic        busy;
      word_t       w;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge CLK);
         busy = nRST && !heard__RDY;
         if (busy && prev_stall) begin
            check("stall_data", msg_data, prev_data);
            check("stall_last", 32'(msg_last), 32'(prev_last));
         end
         if (msg__ENA) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_word", msg_data, 32'hxxxx_xxxx);
            end else begin
               w = exp_q.pop_front();
               check("word_data", msg_data, w.data);
               check("word_last", 32'(msg_last), 32'(w.last));
            end
         end
         if (nRST && heard__RDY) check("idle_data_zero", msg_data, 32'd0);
         prev_stall = busy && !msg__ENA;
         prev_data  = msg_data;
         prev_last  = msg_last;
      end
   end

   logic [3:0] bp_pat = 4'b1001;
   int         bp_ph = 0;
   initial forever begin
      @(posedge CLK);
      #1;
      if (bp_mode) begin
         msg__RDY = bp_pat[bp_ph];
         bp_ph    = (bp_ph + 1) % 4;
      end
   end

   initial begin
      int a0, a1, a2, w0;
      nRST       = 1'b0;
      heard__ENA = 1'b0;
      heard_meth = '0;
      heard_v    = '0;
      msg__RDY   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         meth_a[32*i +: 32] = 32'(i + 1);
         v_a[32*i +: 32]    = 32'(32'hA0 + i);
         meth_b[32*i +: 32] = 32'h1111_0000 + 32'(i);
         v_b[32*i +: 32]    = 32'hBEEF_0000 + 32'(i * 3);
      end

      // Reset state
      repeat (3) tick();
      @(negedge CLK);
      check("rst_heard_rdy", 32'(heard__RDY), 32'd0);
      check("rst_msg_ena", 32'(msg__ENA), 32'd0);
      check("rst_msg_data", msg_data, 32'd0);
      check("rst_msg_last", 32'(msg_last), 32'd0);
      check("rst_msg_count", 32'(msg_count), 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      @(negedge CLK);
      check("post_rst_rdy", 32'(heard__RDY), 32'd1);

      // Single message, no stall
      send(meth_a, v_a, a0);
      check("header_cycle_data", msg_data, 32'h0005_000D);
      check("header_cycle_ena", 32'(msg__ENA), 32'd1);
      repeat (12) tick();
      check("last_word_rdy_low", 32'(heard__RDY), 32'd0);
      check("last_word_flag", 32'(msg_last), 32'd1);
      check("last_word_data", msg_data, 32'h0000_00A5);
      tick();
      check("rdy_after_13", 32'(heard__RDY), 32'd1);
      check("count_after_1", 32'(msg_count), 32'd1);
      check("queue_drained_1", exp_q.size(), 32'd0);

      // Back-pressure 1,0,0,1,...
      bp_ph   = 0;
      bp_mode = 1'b1;
      send(meth_a, v_a, a0);
      wait_idle();
      bp_mode  = 1'b0;
      msg__RDY = 1'b1;
      check("count_after_bp", 32'(msg_count), 32'(exp_count));
      check("queue_drained_bp", exp_q.size(), 32'd0);

      // Illegal accept while sending
      send(meth_b, v_b, a0);
      repeat (3) tick();
      heard_meth = ~meth_b;
      heard_v    = ~v_b;
      heard__ENA = 1'b1;
      tick();
      heard__ENA = 1'b0;
      wait_idle();
      repeat (3) tick();
      check("illegal_stays_idle", 32'(heard__RDY), 32'd1);
      check("queue_drained_ill", exp_q.size(), 32'd0);
      check("count_after_ill", 32'(msg_count), 32'(exp_count));

      // Reset after word 5 is transferred
      send(meth_a, v_a, a0);
      repeat (6) tick();
      check("pre_reset_remaining", exp_q.size(), 32'd7);
      nRST = 1'b0;
      exp_q.delete();
      exp_count = '0;
      @(negedge CLK);
      check("mid_rst_ena", 32'(msg__ENA), 32'd0);
      check("mid_rst_count", 32'(msg_count), 32'd0);
      tick();
      tick();
      nRST = 1'b1;
      @(negedge CLK);
      check("post_mid_rst_rdy", 32'(heard__RDY), 32'd1);
      check("post_mid_rst_count", 32'(msg_count), 32'd0);
      send(meth_b, v_b, a0);
      check("post_rst_header", msg_data, 32'h0005_000D);
      wait_idle();
      check("count_post_rst", 32'(msg_count), 32'd1);

      // Back-to-back x3 from a clean count
      do_reset();
      w0 = words_seen;
      send(meth_a, v_a, a0);
      send(meth_b, v_b, a1);
      send(v_a, meth_b, a2);
      wait_idle();
      check("b2b_spacing_1", 32'(a1 - a0), 32'd14);
      check("b2b_spacing_2", 32'(a2 - a1), 32'd14);
      check("b2b_words", 32'(words_seen - w0), 32'd39);
      check("b2b_count", 32'(msg_count), 32'd3);
      check("queue_drained_b2b", exp_q.size(), 32'd0);

      // Counter wrap
      force dut.count_q = 16'hFFFF;
      tick();
      release dut.count_q;
      tick();
      check("wrap_preload", 32'(msg_count), 32'h0000_FFFF);
      send(meth_b, v_a, a0);
      wait_idle();
      check("wrap_count", 32'(msg_count), 32'd0);
      check("queue_drained_wrap", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ivector_heard_serializer.md
# ivector_heard_serializer

Downstream consumer of the IVector `heard(meth, v)` indication. It accepts one 384-bit indication (two 192-bit vectors) through an ENA/RDY method port, holds it in a one-message buffer, and emits it as a 13-word, 32-bit message stream: one header word followed by 12 payload words. It sits between the IVector block's `ind$heard` port and the host indication pipe, with back-pressure in both directions.

## Interface
- METHOD_ID, 16'd0: value placed in header bits [31:16].
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, synchronous, active-low.
- heard__ENA  input  1  upstream invokes `heard`; asserted only while heard__RDY=1.
- heard_meth  input  192  first vector argument.
- heard_v  input  192  second vector argument.
- heard__RDY  output  1  buffer empty; block can accept `heard`.
- msg__ENA  output  1  word transfer this cycle, =busy & msg__RDY.
- msg_data  output  32  current word; valid while busy.
- msg_last  output  1  current word is the final word (index 12).
- msg__RDY  input  1  downstream pipe can take a word.
- msg_count  output  16  count of completed messages, wraps at 2^16.

## Operation
- States: IDLE (buffer empty) and SEND (buffer holds a message). Registers: buf[383:0], idx[3:0], msg_count[15:0].
- IDLE: heard__RDY=1 and msg__ENA=0. On heard__ENA: buf <= {heard_v, heard_meth}, idx <= 0, next state SEND.
- SEND: heard__RDY=0. msg_data is selected by idx:
  - idx 0: header {METHOD_ID, 16'd13}.
  - idx 1..6: heard_meth words, least significant first; word k = meth[32(k-1)+31 : 32(k-1)].
  - idx 7..12: heard_v words, least significant first; word k = v[32(k-7)+31 : 32(k-7)].
- msg_last = SEND & (idx==12).
- Each cycle with msg__ENA=1, idx advances by 1. On the cycle where msg__ENA=1 and idx==12: state returns to IDLE, idx <= 0, and msg_count increments by 1 (modulo 2^16).
- When msg__RDY=0, idx, msg_data and msg_last hold steady. The stall length is unbounded.
- While IDLE, msg_data=0.
- heard__ENA while heard__RDY=0 is a protocol violation. It is ignored: buf, state and idx are unchanged.
- Reset (nRST=0 at a clock edge): state IDLE, idx 0, msg_count 0, buf contents don't-care. Any in-flight message is discarded with no further words emitted.
- Outputs during and after reset: heard__RDY is forced to 0 while nRST=0, then reads 1 on the first cycle after release. msg__ENA=0, msg_last=0, msg_data=0, msg_count=0.

## Timing
- Accept latency: heard__ENA at edge N puts the header on msg_data during cycle N+1. msg__ENA is high in that cycle if msg__RDY=1.
- With msg__RDY held high, the 13 words occupy cycles N+1..N+13. heard__RDY returns to 1 in cycle N+14.
- Minimum spacing between accepted messages is 14 cycles. Accept and send never overlap.
- msg__ENA is a combinational function of registered state and msg__RDY. heard__RDY depends only on registered state and nRST, with no path from msg__RDY.
- msg_count updates on the same edge that consumes the last word. The new value is visible in the following cycle.

## Test plan
- Single message, no stall: meth=192'h…_0000000200000001 (word k = k), v word k = 'hA0+k, METHOD_ID=16'h0005. Required: words 0x0005000D, 1..6, 0xA0..0xA5. msg_last only on the 13th word; msg_count 0→1; heard__RDY high again 13 cycles after the header cycle.
- Back-pressure: same message, msg__RDY toggles 1,0,0,1,…. Required: identical 13-word sequence with no duplicate or skipped word. msg_data stable through every stall.
- Illegal accept: pulse heard__ENA with different data while in SEND. Required: the original message is emitted unchanged.
- Reset mid-message: assert nRST=0 after word 5 is transferred. Required: msg__ENA=0 next cycle, msg_count=0. After release, a new message emits from header onward.
- Back-to-back: upstream issues heard__ENA as soon as heard__RDY=1, for 3 messages. Required: 39 words total at 14-cycle message spacing, msg_count=3.
- Counter wrap: preload or run until msg_count=16'hFFFF, then send one message. Required: msg_count reads 0.
